neuron_mac_stage: RTL

Datapath stage directly downstream of the layer address generator. Consumes the weight/neuron operand pairs read from weight and neuron memory at the generated addresses. Performs a signed fixed-point multiply-accumulate over the inputs of each neuron, then writes one rescaled, saturated result per neuron back to neuron memory at the generated write address. Signals layer completion to the layer sequencer.

---
 rtl/neuron_mac_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/neuron_mac_stage.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac_stage
// Description : Signed fixed-point multiply-accumulate stage that writes one
//               rescaled, saturated result per neuron back to neuron memory.
//               Optional macro NEURON_RELU_EN clamps negative results to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac_stage #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              in_final,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] neuro,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam int c_PROD_W = 2 * DATA_W;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam logic signed [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] c_RES_MAX = (ACC_W)'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W-1:0] c_RES_MIN = ~c_RES_MAX;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_next;
    logic                       r_s1_valid;
    logic                       r_s1_last;
    logic                       r_s1_final;
    logic [ADDR_W-1:0]          r_s1_waddr;
    logic signed [c_PROD_W-1:0] r_prod;
    logic signed [ACC_W-1:0]    r_acc;

    logic signed [DATA_W-1:0]   w_weight_s;
    logic signed [DATA_W-1:0]   w_neuro_s;
    logic                       w_take;
    logic                       w_retire;
    logic signed [ACC_W:0]      w_sum_wide;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    w_shift;
    logic signed [DATA_W-1:0]   w_sat;
    logic signed [DATA_W-1:0]   w_res;

    assign w_weight_s = weight;
    assign w_neuro_s  = neuro;

    // A start in any state wins over the operand or product seen that cycle.
    assign w_take   = (r_state == c_RUN) && in_valid && !start;
    assign w_retire = r_s1_valid && r_s1_last && !start;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) w_state_next = c_RUN;
            end
            c_RUN: begin
                if (!start && w_take && in_last && in_final) w_state_next = c_DRAIN;
            end
            c_DRAIN: begin
                if (start)                       w_state_next = c_RUN;
                else if (w_retire && r_s1_final) w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // One guard bit detects accumulator overflow before clamping.
    assign w_sum_wide = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_prod);

    always_comb begin
        w_sum = w_sum_wide[ACC_W-1:0];
        if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
            w_sum = w_sum_wide[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
        end
    end

    assign w_shift = w_sum >>> FRAC_W;

    always_comb begin
        w_sat = w_shift[DATA_W-1:0];
        if (w_shift > c_RES_MAX)      w_sat = c_RES_MAX[DATA_W-1:0];
        else if (w_shift < c_RES_MIN) w_sat = c_RES_MIN[DATA_W-1:0];
    end

`ifdef NEURON_RELU_EN
    assign w_res = w_sat[DATA_W-1] ? '0 : w_sat;
`else
    assign w_res = w_sat;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_final <= 1'b0;
            r_s1_waddr <= '0;
            r_prod     <= '0;
            r_acc      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_s1_valid <= w_take;
            wr_en      <= w_retire;
            done       <= w_retire && r_s1_final;

            if (w_take) begin
                r_prod     <= (c_PROD_W)'(w_weight_s) * (c_PROD_W)'(w_neuro_s);
                r_s1_last  <= in_last;
                r_s1_final <= in_last && in_final;
                r_s1_waddr <= in_waddr;
            end

            // The last product of a neuron leaves the accumulator at zero so the
            // next neuron can start on the following edge without a bubble.
            if (start)           r_acc <= '0;
            else if (r_s1_valid) r_acc <= r_s1_last ? '0 : w_sum;

            if (w_retire) begin
                wr_addr <= r_s1_waddr;
                wr_data <= w_res;
            end
        end
    end

    assign busy = (r_state != c_IDLE);

endmodule
`default_nettype wire
